sr_latch: RTL and testbench
===========================

// Module: sr_latch
// PURPOSE
//   Clocked, enable-gated set/reset storage element: WIDTH independent S/R bits.
//   Each bit holds a state, sets on S, clears on R and holds when En is low.
//   S=R=1 is resolved by a parameterised policy and reported on a flag.
//   Used as a general control/status flag register in datapath and control logic.
// PARAMETERS
//   WIDTH      1         number of independent S/R bits
//   CONFLICT   HOLD      per-bit resolution of S=R=1: HOLD, SET or CLR (package enum)
//   RESET_VAL  '0        WIDTH-bit value loaded into Q on reset
// PORTS
//   clk      in   1      rising-edge clock; all state changes occur here
//   rst      in   1      synchronous, active-high reset
//   S        in   WIDTH  per-bit set request
//   R        in   WIDTH  per-bit reset request
//   En       in   1      global enable; when 0 all bits hold
//   Q        out  WIDTH  stored state
//   Qn       out  WIDTH  complement of Q, always exactly ~Q
//   conflict out  1      registered; 1 if any bit had S=R=1 with En=1 last cycle
// BEHAVIOUR
//   - Reset is synchronous and active-high; sampled on rising clk edge, has priority over all.
//   - rst=1 at edge: Q<=RESET_VAL, conflict<=0; Qn follows as ~RESET_VAL.
//   - Per bit i at each rising edge with rst=0:
//       En=0                 -> Q[i] holds
//       En=1,S=0,R=0         -> Q[i] holds
//       En=1,S=1,R=0         -> Q[i]<=1
//       En=1,S=0,R=1         -> Q[i]<=0
//       En=1,S=1,R=1         -> HOLD: keep; SET: 1; CLR: 0 (per CONFLICT)
//   - Latency: one cycle; Q reflects request at the edge where it is sampled.
//   - Qn combinational from Q; never equal to Q (no S=R=1 "both-zero" state).
//   - conflict<=|(S&R) & En each cycle; not sticky; cleared by reset.
//   - Bits independent: mixed set/clear/hold in same cycle allowed.
//   - Inputs X/Z not handled; inputs must be driven when En=1.
//   - No combinational path S/R/En -> Q.
// STRUCTURE
//   - Package sr_latch_pkg: typedef enum {HOLD, SET, CLR} conflict_e.
//   - Sub-module sr_cell: one bit (clk, rst, s, r, en -> q, conflict_bit),
//     instantiated WIDTH times by generate; top ORs conflict_bit, registers flag.
// TESTING
//   1. rst=1 one cycle -> Q=RESET_VAL(0), Qn=1, conflict=0.
//   2. WIDTH=1: S=0,R=1,En=1 -> Q=0 next edge; S=1,R=0,En=1 -> Q=1 next edge.
//   3. Q=1, then S=1,R=1,En=0 -> Q stays 1, conflict=0.
//   4. Q=0, S=1,R=1,En=1, CONFLICT=HOLD -> Q=0, conflict=1; SET -> Q=1; CLR -> Q=0.
//   5. WIDTH=4, Q=4'b0101, S=4'b1000,R=4'b0001,En=1 -> Q=4'b1100, Qn=4'b0011.
//   6. Q=1, rst=1 and S=1,En=1 same edge -> Q=0 (reset wins); conflict=0.

Source files
------------

// File: rtl/sr_latch_pkg.sv
// Shared types and the per-bit next-state rule for the S/R flag register.
package sr_latch_pkg;

    // Resolution applied to a bit when set and reset are requested together.
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        SET  = 2'd1,
        CLR  = 2'd2
    } conflict_e;

    localparam int unsigned DEFAULT_WIDTH = 1;

    // Next value of one enabled bit given its request pair and current state.
    function automatic logic resolve_bit(
        input logic      s,
        input logic      r,
        input logic      q,
        input conflict_e policy
    );
        logic nxt;
        nxt = q;
        unique case ({s, r})
            2'b10:   nxt = 1'b1;
            2'b01:   nxt = 1'b0;
            2'b11: begin
                unique case (policy)
                    SET:     nxt = 1'b1;
                    CLR:     nxt = 1'b0;
                    default: nxt = q;
                endcase
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_latch_if.sv
// Request/state bundle between a flag-register user and the sr_latch block.
interface sr_latch_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] R;
    logic             En;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qn;
    logic             conflict;

    // Requester side: drives set/reset/enable, observes the stored state.
    modport master (
        output S,
        output R,
        output En,
        input  Q,
        input  Qn,
        input  conflict
    );

    // Storage side: receives requests, presents the stored state.
    modport slave (
        input  S,
        input  R,
        input  En,
        output Q,
        output Qn,
        output conflict
    );
endinterface

// File: rtl/sr_latch_cell.sv
// One clocked, enable-gated S/R storage bit with a per-bit conflict indication.
module sr_cell
    import sr_latch_pkg::*;
#(
    parameter conflict_e CONFLICT  = HOLD,
    parameter logic      RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    input  logic en,
    output logic q,
    output logic conflict_bit
);

    logic q_d;
    logic q_q;

    // Next state: hold when disabled, otherwise apply the request rule.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = resolve_bit(s, r, q_q, CONFLICT);
        end
    end

    // State register; synchronous reset has priority over any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q            = q_q;
    assign conflict_bit = s & r & en;

endmodule

// File: rtl/sr_latch.sv
// WIDTH independent S/R flag bits with a registered "simultaneous S and R" flag.
module sr_latch
    import sr_latch_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
    parameter conflict_e        CONFLICT  = HOLD,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic       clk,
    input  logic       rst,
    sr_latch_if.slave  bus
);

    logic [WIDTH-1:0] q_bits;
    logic [WIDTH-1:0] conflict_bits;
    logic             conflict_d;
    logic             conflict_q;

    // One storage cell per bit; bits never interact.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        sr_cell #(
            .CONFLICT  (CONFLICT),
            .RESET_VAL (RESET_VAL[i])
        ) u_cell (
            .clk          (clk),
            .rst          (rst),
            .s            (bus.S[i]),
            .r            (bus.R[i]),
            .en           (bus.En),
            .q            (q_bits[i]),
            .conflict_bit (conflict_bits[i])
        );
    end

    // Any enabled bit seeing S and R together raises the flag for one cycle.
    always_comb begin
        conflict_d = |conflict_bits;
    end

    // Conflict flag register; reset clears it, otherwise it is not sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign bus.Q        = q_bits;
    assign bus.Qn       = ~q_bits;
    assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_sr_latch.sv
// Scoreboard bench: four sr_latch configurations driven with shared stimulus.
module tb_sr_latch;
    import sr_latch_pkg::*;

    logic clk;
    logic rst;

    sr_latch_if #(.WIDTH(4)) if0 ();
    sr_latch_if #(.WIDTH(4)) if1 ();
    sr_latch_if #(.WIDTH(4)) if2 ();
    sr_latch_if #(.WIDTH(1)) if3 ();

    sr_latch #(.WIDTH(4), .CONFLICT(HOLD), .RESET_VAL(4'b0000)) u_hold (.clk(clk), .rst(rst), .bus(if0));
    sr_latch #(.WIDTH(4), .CONFLICT(SET),  .RESET_VAL(4'b1010)) u_set  (.clk(clk), .rst(rst), .bus(if1));
    sr_latch #(.WIDTH(4), .CONFLICT(CLR),  .RESET_VAL(4'b0000)) u_clr  (.clk(clk), .rst(rst), .bus(if2));
    sr_latch #(.WIDTH(1), .CONFLICT(HOLD), .RESET_VAL(1'b1))    u_one  (.clk(clk), .rst(rst), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {conflict, Q} per instance, pushed at stimulus time.
    logic [4:0] exp_q0[$];
    logic [4:0] exp_q1[$];
    logic [4:0] exp_q2[$];
    logic [4:0] exp_q3[$];

    int compared;
    int mismatched;
    bit stim_done;

    // Reference state per instance: 0=HOLD/w4, 1=SET/w4, 2=CLR/w4, 3=HOLD/w1.
    logic [3:0] m_q[4];
    int         m_pol[4];
    int         m_w[4];
    logic [3:0] m_rv[4];

    // Stored value after one edge, computed bit by bit from the truth table.
    function automatic logic [3:0] model_next(input logic [3:0] q, input logic [3:0] s,
                                              input logic [3:0] r, input logic en,
                                              input int pol, input int w);
        logic [3:0] n;
        n = q;
        for (int i = 0; i < w; i++) begin
            if (en) begin
                if (s[i] && !r[i])      n[i] = 1'b1;
                else if (!s[i] && r[i]) n[i] = 1'b0;
                else if (s[i] && r[i])  n[i] = (pol == 1) ? 1'b1 : (pol == 2) ? 1'b0 : q[i];
            end
        end
        for (int i = w; i < 4; i++) n[i] = 1'b0;
        return n;
    endfunction

    function automatic logic model_conflict(input logic [3:0] s, input logic [3:0] r,
                                            input logic en, input int w);
        logic c;
        c = 1'b0;
        for (int i = 0; i < w; i++) if (en && s[i] && r[i]) c = 1'b1;
        return c;
    endfunction

    // Drive one cycle of requests and record what each instance must show after the edge.
    task automatic apply(input logic r_st, input logic [3:0] s, input logic [3:0] r, input logic en);
        logic [4:0] e[4];
        @(negedge clk);
        rst = r_st;
        if0.S = s;  if0.R = r;  if0.En = en;
        if1.S = s;  if1.R = r;  if1.En = en;
        if2.S = s;  if2.R = r;  if2.En = en;
        if3.S = s[0:0]; if3.R = r[0:0]; if3.En = en;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] wmask;
            wmask = (m_w[k] == 4) ? 4'hF : 4'h1;
            if (r_st) begin
                m_q[k] = m_rv[k] & wmask;
                e[k]   = {1'b0, m_q[k]};
            end else begin
                e[k]   = {model_conflict(s, r, en, m_w[k]),
                          model_next(m_q[k], s, r, en, m_pol[k], m_w[k])};
                m_q[k] = e[k][3:0];
            end
        end
        exp_q0.push_back(e[0]);
        exp_q1.push_back(e[1]);
        exp_q2.push_back(e[2]);
        exp_q3.push_back(e[3]);
    endtask

    task automatic check(input string name, input logic [3:0] act_q, input logic [3:0] act_qn,
                         input logic act_c, input logic [4:0] exp, input logic [3:0] wmask);
        compared++;
        if ((act_q & wmask) !== exp[3:0] || (act_qn & wmask) !== (~exp[3:0] & wmask) || act_c !== exp[4]) begin
            mismatched++;
            $display("FAIL %s @%0t: Q=%b Qn=%b conflict=%b, required Q=%b Qn=%b conflict=%b",
                     name, $time, act_q & wmask, act_qn & wmask, act_c,
                     exp[3:0], ~exp[3:0] & wmask, exp[4]);
        end
    endtask

    // Monitor: after each edge, pop the pending expectation and compare.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q0.size() > 0) check("hold_w4", if0.Q, if0.Qn, if0.conflict, exp_q0.pop_front(), 4'hF);
            if (exp_q1.size() > 0) check("set_w4",  if1.Q, if1.Qn, if1.conflict, exp_q1.pop_front(), 4'hF);
            if (exp_q2.size() > 0) check("clr_w4",  if2.Q, if2.Qn, if2.conflict, exp_q2.pop_front(), 4'hF);
            if (exp_q3.size() > 0) check("hold_w1", {3'b000, if3.Q}, {3'b000, if3.Qn}, if3.conflict,
                                         exp_q3.pop_front(), 4'h1);
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        stim_done  = 1'b0;
        m_pol = '{0, 1, 2, 0};
        m_w   = '{4, 4, 4, 1};
        m_rv  = '{4'b0000, 4'b1010, 4'b0000, 4'b0001};
        for (int k = 0; k < 4; k++) m_q[k] = 4'b0000;
        rst = 1'b1;
        if0.S = '0; if0.R = '0; if0.En = 1'b0;
        if1.S = '0; if1.R = '0; if1.En = 1'b0;
        if2.S = '0; if2.R = '0; if2.En = 1'b0;
        if3.S = '0; if3.R = '0; if3.En = 1'b0;

        // Directed: reset, clear, set, disabled conflict, enabled conflict.
        apply(1'b1, 4'b0000, 4'b0000, 1'b0);
        apply(1'b0, 4'b0000, 4'b0001, 1'b1);
        apply(1'b0, 4'b0001, 4'b0000, 1'b1);
        apply(1'b0, 4'b0001, 4'b0001, 1'b0);
        apply(1'b0, 4'b0000, 4'b0001, 1'b1);
        apply(1'b0, 4'b0001, 4'b0001, 1'b1);
        apply(1'b0, 4'b0000, 4'b0000, 1'b1);
        // Mixed per-bit operations from a known pattern.
        apply(1'b1, 4'b0000, 4'b0000, 1'b0);
        apply(1'b0, 4'b0101, 4'b1010, 1'b1);
        apply(1'b0, 4'b1000, 4'b0001, 1'b1);
        apply(1'b0, 4'b1111, 4'b1111, 1'b1);
        // Reset wins over a simultaneous set.
        apply(1'b0, 4'b0001, 4'b0000, 1'b1);
        apply(1'b1, 4'b1111, 4'b0000, 1'b1);
        apply(1'b1, 4'b1111, 4'b1111, 1'b1);
        apply(1'b0, 4'b0000, 4'b0000, 1'b0);

        // Randomised traffic.
        for (int n = 0; n < 300; n++) begin
            apply(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
                  4'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end
        stim_done = 1'b1;

        repeat (4) @(posedge clk);
        #3;
        compared++;
        if (exp_q0.size() + exp_q1.size() + exp_q2.size() + exp_q3.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, required 0",
                     exp_q0.size() + exp_q1.size() + exp_q2.size() + exp_q3.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
